// File: rtl/fifo_burst_writer_if.sv
// Handshake bundle between the burst writer, its FIFO read port and the system bus.
interface fifo_burst_writer_if;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_r_en;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_last;
  logic        busy;
  logic        done;
  logic        err;

  // Writer side
  modport master (
    input  start, base_addr, word_count, fifo_empty, fifo_data, bus_gnt, bus_ready,
    output fifo_r_en, bus_req, bus_valid, bus_addr, bus_wdata, bus_last, busy, done, err
  );

  // Environment side: software/FIFO/bus
  modport slave (
    output start, base_addr, word_count, fifo_empty, fifo_data, bus_gnt, bus_ready,
    input  fifo_r_en, bus_req, bus_valid, bus_addr, bus_wdata, bus_last, busy, done, err
  );
endinterface

// File: rtl/fifo_burst_writer.sv
// Drains word_count words from a show-ahead FIFO and writes them to the bus as
// incrementing-address bursts of up to BURST_LEN beats, one arbitration per burst.
module fifo_burst_writer #(
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_burst_writer_if.master bw
);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER, S_DONE} state_e;

  state_e        state_q;
  logic [31:0]   fetch_addr_q;   // address of the next word to be popped
  logic [15:0]   remaining_q;    // words not yet accepted by the bus
  logic [BW-1:0] burst_cnt_q;
  logic [BW-1:0] fetched_q;      // words popped in the current burst
  logic [TW-1:0] idle_cnt_q;
  logic          bus_req_q, bus_valid_q, bus_last_q;
  logic          busy_q, done_q, err_q;
  logic [31:0]   bus_addr_q, bus_wdata_q;

  logic          pop, accept, idle_tick, last_fetch;
  logic [BW-1:0] burst_cnt_d;

  // Pop whenever the output slot is free or being emptied this cycle.
  always_comb begin
    pop         = (state_q == S_XFER) && !bw.fifo_empty && (fetched_q < burst_cnt_q) &&
                  (!bus_valid_q || bw.bus_ready);
    accept      = bus_valid_q && bw.bus_ready;
    idle_tick   = (state_q == S_XFER) && !bus_valid_q && bw.fifo_empty;
    last_fetch  = (fetched_q + BW'(1)) == burst_cnt_q;
    burst_cnt_d = (remaining_q < 16'(BURST_LEN)) ? BW'(remaining_q) : BW'(BURST_LEN);
  end

  // Job FSM with all bus/status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
      remaining_q  <= '0;
      burst_cnt_q  <= '0;
      fetched_q    <= '0;
      idle_cnt_q   <= '0;
      bus_req_q    <= 1'b0;
      bus_valid_q  <= 1'b0;
      bus_last_q   <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bw.start) begin
            fetch_addr_q <= bw.base_addr;
            remaining_q  <= bw.word_count;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
            if (bw.base_addr[1:0] != 2'b00) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (bw.word_count == 16'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              bus_req_q <= 1'b1;
              state_q   <= S_ARB;
            end
          end
        end
        S_ARB: begin
          // Request was dropped for one cycle after a burst; raise it again here.
          if (bus_req_q && bw.bus_gnt) begin
            burst_cnt_q <= burst_cnt_d;
            fetched_q   <= '0;
            idle_cnt_q  <= '0;
            state_q     <= S_XFER;
          end else begin
            bus_req_q <= 1'b1;
          end
        end
        S_XFER: begin
          if (pop) begin
            fetched_q    <= fetched_q + BW'(1);
            fetch_addr_q <= fetch_addr_q + 32'd4;
            bus_addr_q   <= fetch_addr_q;
            bus_wdata_q  <= bw.fifo_data;
            bus_valid_q  <= 1'b1;
            bus_last_q   <= last_fetch;
            idle_cnt_q   <= '0;
          end else if (accept) begin
            bus_valid_q <= 1'b0;
            bus_last_q  <= 1'b0;
          end
          if (accept) begin
            remaining_q <= remaining_q - 16'd1;
            if (bus_last_q) begin
              bus_req_q <= 1'b0;
              if (remaining_q == 16'd1) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                state_q <= S_ARB;
              end
            end
          end else if (idle_tick) begin
            // Starved: abort once TIMEOUT consecutive empty cycles have passed.
            if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
              err_q       <= 1'b1;
              bus_req_q   <= 1'b0;
              bus_valid_q <= 1'b0;
              bus_last_q  <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              idle_cnt_q <= idle_cnt_q + TW'(1);
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bw.fifo_r_en = pop;
  assign bw.bus_req   = bus_req_q;
  assign bw.bus_valid = bus_valid_q;
  assign bw.bus_addr  = bus_addr_q;
  assign bw.bus_wdata = bus_wdata_q;
  assign bw.bus_last  = bus_last_q;
  assign bw.busy      = busy_q;
  assign bw.done      = done_q;
  assign bw.err       = err_q;
endmodule

// File: tb/tb_fifo_burst_writer.sv
// Bench for fifo_burst_writer: queue-based FIFO and bus slave, vector table,
// hand-written reset/wrap sequence, random jobs against a transfer-level model.
module tb_fifo_burst_writer;
  localparam int BL = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_burst_writer_if bw();
  fifo_burst_writer #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bw(bw));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    string       name;
    logic [31:0] base;
    int          cnt;
    int          supply;
    int          mode;      // 0 ready=1, 1 ready toggles, 2 random gnt/ready
    bit          exp_err;
    int          exp_beats;
  } vec_t;

  logic [31:0] fq[$];
  logic [31:0] wd[$];
  beat_t       beats[$];
  int          pops, done_cnt, idle_cyc, req_seen, exp_total, ready_mode;
  bit          popped_any, tog, p_lastacc;
  logic        p_valid, p_ready, p_last;
  logic [31:0] p_addr, p_data;

  task automatic drive_fifo();
    bw.fifo_empty = (fq.size() == 0);
    bw.fifo_data  = (fq.size() != 0) ? fq[0] : 32'h0;
  endtask

  // One clock: observe at negedge, apply FIFO pop and new bus inputs after posedge.
  task automatic step();
    bit    pop_now;
    bit    acc;
    beat_t b;
    @(negedge clk);
    check("pop_when_empty", 32'(bw.fifo_r_en & bw.fifo_empty), 32'h0);
    check("pop_in_stall", 32'(bw.fifo_r_en & bw.bus_valid & ~bw.bus_ready), 32'h0);
    check("valid_without_req", 32'(bw.bus_valid & ~bw.bus_req), 32'h0);
    if (p_valid && !p_ready) begin
      check("hold_valid", 32'(bw.bus_valid), 32'h1);
      check("hold_addr", bw.bus_addr, p_addr);
      check("hold_data", bw.bus_wdata, p_data);
      check("hold_last", 32'(bw.bus_last), 32'(p_last));
    end
    if (p_lastacc) check("req_gap", 32'(bw.bus_req), 32'h0);
    acc = bw.bus_valid && bw.bus_ready;
    if (acc) begin
      b.addr = bw.bus_addr; b.data = bw.bus_wdata; b.last = bw.bus_last;
      beats.push_back(b);
    end
    p_lastacc = acc && bw.bus_last && (beats.size() < exp_total);
    if (bw.done) done_cnt++;
    if (bw.bus_req) req_seen++;
    if (popped_any && bw.busy && !bw.done && !bw.bus_valid && bw.fifo_empty) idle_cyc++;
    pop_now = bw.fifo_r_en;
    if (pop_now) begin pops++; popped_any = 1'b1; end
    p_valid = bw.bus_valid; p_ready = bw.bus_ready; p_last = bw.bus_last;
    p_addr = bw.bus_addr; p_data = bw.bus_wdata;
    @(posedge clk);
    #1;
    if (pop_now && fq.size() != 0) void'(fq.pop_front());
    tog = ~tog;
    case (ready_mode)
      1: begin bw.bus_ready = tog; bw.bus_gnt = 1'b1; end
      2: begin bw.bus_ready = ($urandom_range(0, 3) != 0); bw.bus_gnt = ($urandom_range(0, 2) != 0); end
      default: begin bw.bus_ready = 1'b1; bw.bus_gnt = 1'b1; end
    endcase
    drive_fifo();
  endtask

  task automatic setup_job(input logic [31:0] base, input int cnt, input int supply,
                           input int mode, input int exp_beats);
    logic [31:0] w;
    fq.delete(); wd.delete(); beats.delete();
    for (int i = 0; i < supply; i++) begin
      w = $urandom;
      fq.push_back(w); wd.push_back(w);
    end
    pops = 0; done_cnt = 0; idle_cyc = 0; req_seen = 0; popped_any = 1'b0;
    p_valid = 1'b0; p_ready = 1'b0; p_lastacc = 1'b0;
    exp_total = exp_beats; ready_mode = mode;
    drive_fifo();
    bw.base_addr = base; bw.word_count = 16'(cnt); bw.start = 1'b1;
    step();
    bw.start = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [31:0] base, input int cnt, input int supply,
                         input int mode, input bit exp_err, input int exp_beats);
    int  cyc;
    bit  exp_last;
    setup_job(base, cnt, supply, mode, exp_beats);
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin step(); cyc++; end
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'h1);
    step(); step();
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'h1);
    check({tag, "_err"}, 32'(bw.err), 32'(exp_err));
    check({tag, "_busy_idle"}, 32'(bw.busy), 32'h0);
    check({tag, "_beats"}, 32'(beats.size()), 32'(exp_beats));
    check({tag, "_pops"}, 32'(pops), 32'(exp_beats));
    check({tag, "_fifo_left"}, 32'(fq.size()), 32'(supply - exp_beats));
    for (int i = 0; i < beats.size() && i < exp_beats; i++) begin
      exp_last = ((i % BL) == BL - 1) || (i == cnt - 1);
      check($sformatf("%s_addr%0d", tag, i), beats[i].addr, base + 32'(4 * i));
      check($sformatf("%s_data%0d", tag, i), beats[i].data, wd[i]);
      check($sformatf("%s_last%0d", tag, i), 32'(beats[i].last), 32'(exp_last));
    end
    if (exp_beats == 0) check({tag, "_no_req"}, 32'(req_seen), 32'h0);
    if (exp_err && base[1:0] == 2'b00) check({tag, "_idle_cycles"}, 32'(idle_cyc), 32'(TO));
  endtask

  // Transfer-level expectation: what a job should achieve, from its inputs alone.
  task automatic model(input logic [31:0] base, input int cnt, input int supply,
                       output bit err, output int nbeats);
    if (base[1:0] != 2'b00) begin err = 1'b1; nbeats = 0; end
    else if (cnt == 0)      begin err = 1'b0; nbeats = 0; end
    else if (supply < cnt)  begin err = 1'b1; nbeats = supply; end
    else                    begin err = 1'b0; nbeats = cnt; end
  endtask

  vec_t vt[6];

  initial begin
    bit          m_err;
    int          m_beats, cnt, k, pops_at_rst;
    logic [31:0] base;

    vt[0] = '{"burst8",   32'h0000_1000, 8, 8, 0, 1'b0, 8};
    vt[1] = '{"split5",   32'h0000_2000, 5, 8, 0, 1'b0, 5};
    vt[2] = '{"stall",    32'h0000_3000, 6, 6, 1, 1'b0, 6};
    vt[3] = '{"misalign", 32'h0000_1002, 4, 4, 0, 1'b1, 0};
    vt[4] = '{"zero",     32'h0000_4000, 0, 2, 0, 1'b0, 0};
    vt[5] = '{"timeout",  32'h0000_5000, 4, 2, 0, 1'b1, 2};

    bw.start = 1'b0; bw.base_addr = '0; bw.word_count = '0;
    bw.bus_gnt = 1'b1; bw.bus_ready = 1'b1;
    fq.delete(); drive_fifo();
    tog = 1'b0; ready_mode = 0; exp_total = 0;
    p_valid = 1'b0; p_ready = 1'b0; p_lastacc = 1'b0;

    #12;
    check("rst_fifo_r_en", 32'(bw.fifo_r_en), 32'h0);
    check("rst_bus_req", 32'(bw.bus_req), 32'h0);
    check("rst_bus_valid", 32'(bw.bus_valid), 32'h0);
    check("rst_bus_last", 32'(bw.bus_last), 32'h0);
    check("rst_busy", 32'(bw.busy), 32'h0);
    check("rst_done", 32'(bw.done), 32'h0);
    check("rst_err", 32'(bw.err), 32'h0);
    check("rst_bus_addr", bw.bus_addr, 32'h0);
    check("rst_bus_wdata", bw.bus_wdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      run_job(vt[i].name, vt[i].base, vt[i].cnt, vt[i].supply, vt[i].mode, vt[i].exp_err, vt[i].exp_beats);

    // Reset in the middle of a burst, then rerun the same job across the address wrap.
    setup_job(32'hFFFF_FFF8, 4, 4, 0, 4);
    k = 0;
    while (beats.size() < 2 && k < 50) begin step(); k++; end
    check("midrst_reached_beat", 32'(beats.size() >= 2), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_fifo_r_en", 32'(bw.fifo_r_en), 32'h0);
    check("midrst_bus_req", 32'(bw.bus_req), 32'h0);
    check("midrst_bus_valid", 32'(bw.bus_valid), 32'h0);
    check("midrst_bus_last", 32'(bw.bus_last), 32'h0);
    check("midrst_busy", 32'(bw.busy), 32'h0);
    check("midrst_done", 32'(bw.done), 32'h0);
    check("midrst_err", 32'(bw.err), 32'h0);
    check("midrst_bus_addr", bw.bus_addr, 32'h0);
    check("midrst_bus_wdata", bw.bus_wdata, 32'h0);
    pops_at_rst = pops;
    done_cnt = 0;
    step(); step();
    check("midrst_no_pop", 32'(pops), 32'(pops_at_rst));
    check("midrst_no_done", 32'(done_cnt), 32'h0);
    rst_n = 1'b1;
    step();
    run_job("wrap", 32'hFFFF_FFF8, 4, 4, 0, 1'b0, 4);

    // Random jobs with random grant/ready back-pressure.
    for (int j = 0; j < 12; j++) begin
      base = $urandom;
      base[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFF0 | (base & 32'h3);
      cnt = $urandom_range(1, 20);
      model(base, cnt, cnt, m_err, m_beats);
      run_job($sformatf("rnd%0d", j), base, cnt, cnt, 2, m_err, m_beats);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
